am_bip_inserter: RTL and testbench

AM_BIP_INSERTER -- requirements
Module: am_bip_inserter

---
 rtl/am_bip_inserter_pkg.sv | 41 ++++
 rtl/bip_block_parity.sv | 31 +++
 rtl/am_bip_inserter.sv | 143 ++++++++++++++
 tb/tb_am_bip_inserter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_bip_inserter_pkg.sv
// -----------------------------------------------------------------------------
// am_bip_inserter_pkg
// Shared PCS constants for the alignment-marker BIP path. The transmit-side
// inserter and the receive-side AM error counter both import this package so
// that both sides agree on the field positions and on the parity lane mapping.
//   - 66b block geometry (sync header width, block width)
//   - BIP3 / BIP7 field offsets inside an AM block
//   - sync-bit-to-BIP-lane mapping
//   - default AM period and period-counter width
//   - WAIT_AM / RUN state encoding
// -----------------------------------------------------------------------------
package am_bip_inserter_pkg;

    localparam int PCS_NB_BLOCK   = 66;     // 66b block width
    localparam int PCS_NB_BIP     = 8;      // BIP lanes
    localparam int PCS_SYNC_W     = 2;      // sync header occupies bits 1:0
    localparam int PCS_BIP_STRIDE = 8;      // bits per lane pass (k = 0..7)

    // Field positions of the BIP bytes inside an AM block.
    localparam int PCS_BIP3_LSB   = 26;     // BIP3 -> bits 33:26
    localparam int PCS_BIP7_LSB   = 58;     // BIP7 -> bits 65:58

    // Sync header bits fold into these BIP lanes.
    localparam int PCS_SYNC0_BIP  = 3;      // sync bit 0 -> P[3]
    localparam int PCS_SYNC1_BIP  = 4;      // sync bit 1 -> P[4]

    // Blocks per AM period (including the AM itself) and counter width.
    localparam int PCS_AM_PERIOD  = 16384;
    localparam int PCS_NB_COUNTER = 14;

    // BIP values carried by the very first AM after reset, when no period
    // has been accumulated yet.
    localparam logic [PCS_NB_BIP-1:0] PCS_FIRST_BIP3 = 8'h00;
    localparam logic [PCS_NB_BIP-1:0] PCS_FIRST_BIP7 = 8'hFF;

    typedef enum logic {
        WAIT_AM = 1'b0,
        RUN     = 1'b1
    } am_state_e;

endpackage

// File: rtl/bip_block_parity.sv
// -----------------------------------------------------------------------------
// bip_block_parity
// Purely combinational 8-lane parity of one 66b block. Shared by the transmit
// inserter and the receive-side checker.
//   Lane j is the XOR of payload bits 2+j+8k (k = 0..7); lanes 3 and 4 also
//   absorb sync bits 0 and 1 respectively.
// Ports
//   i_block   in  66  block, bits 1:0 are the sync header
//   o_parity  out 8   per-lane parity P[7:0]
// -----------------------------------------------------------------------------
module bip_block_parity
    import am_bip_inserter_pkg::*;
(
    input  logic [PCS_NB_BLOCK-1:0] i_block,
    output logic [PCS_NB_BIP-1:0]   o_parity
);

    localparam int N_PASSES = (PCS_NB_BLOCK - PCS_SYNC_W) / PCS_BIP_STRIDE;

    always_comb begin
        o_parity = '0;
        for (int j = 0; j < PCS_NB_BIP; j++) begin
            for (int k = 0; k < N_PASSES; k++) begin
                o_parity[j] = o_parity[j] ^ i_block[PCS_SYNC_W + j + PCS_BIP_STRIDE * k];
            end
        end
        o_parity[PCS_SYNC0_BIP] = o_parity[PCS_SYNC0_BIP] ^ i_block[0];
        o_parity[PCS_SYNC1_BIP] = o_parity[PCS_SYNC1_BIP] ^ i_block[1];
    end

endmodule

// File: rtl/am_bip_inserter.sv
// -----------------------------------------------------------------------------
// am_bip_inserter
// Fills the BIP3/BIP7 reserved fields of alignment-marker blocks with the
// running bit-interleaved parity of the previous AM period, and flags AMs that
// arrive off-period. One cycle of latency, no backpressure.
//
// Handshake: i_enable qualifies i_data/i_am_insert for the current cycle and
// there is no ready; every enabled block is accepted. o_valid is i_enable
// delayed one cycle and qualifies o_data/o_period_error. While o_valid is low
// o_data holds its last value and o_period_error is 0.
//
// Ports
//   i_clock         in  1        block clock, rising edge
//   i_reset         in  1        asynchronous, active-low reset
//   i_enable        in  1        block valid this cycle
//   i_am_insert     in  1        current block is an AM slot
//   i_data          in  NB_DATA  input block, bits 1:0 = sync header
//   o_data          out NB_DATA  output block, BIP fields filled on AMs
//   o_valid         out 1        o_data valid
//   o_locked        out 1        FSM is in RUN (doubles as the state debug view)
//   o_period_error  out 1        one-cycle pulse for an off-period AM
// -----------------------------------------------------------------------------
module am_bip_inserter
    import am_bip_inserter_pkg::*;
#(
    parameter int NB_DATA    = PCS_NB_BLOCK,
    parameter int NB_BIP     = PCS_NB_BIP,
    parameter int AM_PERIOD  = PCS_AM_PERIOD,
    parameter int NB_COUNTER = PCS_NB_COUNTER
)(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_am_insert,
    input  logic [NB_DATA-1:0] i_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_locked,
    output logic               o_period_error
);

    // Counter value an AM must see: it has been cleared by the previous AM and
    // counted AM_PERIOD-1 data blocks since.
    localparam logic [NB_COUNTER-1:0] PERIOD_LAST = NB_COUNTER'(AM_PERIOD - 1);

    am_state_e            state_q, state_d;
    logic [NB_BIP-1:0]    acc_q, acc_d;
    logic [NB_COUNTER-1:0] cnt_q, cnt_d;
    logic [NB_DATA-1:0]   data_d;
    logic                 period_error_d;

    logic [NB_BIP-1:0]    bip3_field;
    logic [NB_BIP-1:0]    bip7_field;
    logic [NB_DATA-1:0]   am_block;
    logic [NB_BIP-1:0]    in_parity;
    logic [NB_BIP-1:0]    am_parity;

    // Parity of the incoming data block feeds the running accumulator.
    bip_block_parity u_in_parity (
        .i_block  (i_data),
        .o_parity (in_parity)
    );

    // Parity of the AM as it leaves (with its BIP fields already inserted)
    // seeds the next period, so the AM is counted in the period it opens.
    bip_block_parity u_am_parity (
        .i_block  (am_block),
        .o_parity (am_parity)
    );

    // Build the outgoing AM: before lock the fields are the fixed first-AM
    // values, afterwards they are the accumulator and its complement.
    always_comb begin
        bip3_field = (state_q == RUN) ? acc_q  : PCS_FIRST_BIP3;
        bip7_field = (state_q == RUN) ? ~acc_q : PCS_FIRST_BIP7;
        am_block   = i_data;
        am_block[PCS_BIP3_LSB +: NB_BIP] = bip3_field;
        am_block[PCS_BIP7_LSB +: NB_BIP] = bip7_field;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= WAIT_AM;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (i_enable && i_am_insert) begin
            state_d = RUN;
        end
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin
        data_d         = o_data;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        period_error_d = 1'b0;
        if (i_enable) begin
            if (i_am_insert) begin
                data_d         = am_block;
                acc_d          = am_parity;
                cnt_d          = '0;
                period_error_d = (state_q == RUN) && (cnt_q != PERIOD_LAST);
            end else begin
                data_d = i_data;
                // Accumulator stays at 0 until the first AM has been seen.
                if (state_q == RUN) begin
                    acc_d = acc_q ^ in_parity;
                end
                // Saturate so a long AM outage is never mistaken for on-period.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + NB_COUNTER'(1);
                end
            end
        end
    end

    // ---------------- datapath and output register ----------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data         <= '0;
            o_valid        <= 1'b0;
            o_period_error <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
        end else begin
            o_data         <= data_d;
            o_valid        <= i_enable;
            o_period_error <= period_error_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
        end
    end

    assign o_locked = (state_q == RUN);

endmodule

// File: tb/tb_am_bip_inserter.sv
// -----------------------------------------------------------------------------
// tb_am_bip_inserter
// Directed + randomized bench for am_bip_inserter with AM_PERIOD=4 and a
// 4-bit period counter (saturates at 15). The reference model keeps every
// block emitted since the last AM in a queue and derives each BIP by XOR-ing
// the definition-level parity of those blocks; an independent receive-side
// checker recomputes BIP from the output stream for the loopback test.
// -----------------------------------------------------------------------------
module tb_am_bip_inserter;

    localparam int NB_DATA    = 66;
    localparam int NB_BIP     = 8;
    localparam int AM_PERIOD  = 4;
    localparam int NB_COUNTER = 4;
    localparam int CNT_MAX    = (1 << NB_COUNTER) - 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic i_reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic               i_enable;
    logic               i_am_insert;
    logic [NB_DATA-1:0] i_data;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               o_locked;
    logic               o_period_error;

    am_bip_inserter #(
        .NB_DATA    (NB_DATA),
        .NB_BIP     (NB_BIP),
        .AM_PERIOD  (AM_PERIOD),
        .NB_COUNTER (NB_COUNTER)
    ) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_am_insert    (i_am_insert),
        .i_data         (i_data),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_locked       (o_locked),
        .o_period_error (o_period_error)
    );

    // ---------------- scoreboard / model state ----------------
    logic [NB_DATA-1:0] exp_q[$];
    logic [NB_DATA-1:0] m_q[$];       // blocks emitted since the last AM
    logic [NB_DATA-1:0] m_last;
    bit                 m_locked;

    int n_checks;
    int n_pass;
    int n_fail;

    // receive-side checker
    bit                 rx_on;
    bit                 rx_locked;
    logic [NB_BIP-1:0]  rx_acc;
    int                 rx_err;
    logic [NB_DATA-1:0] rx_flip;

    logic [NB_DATA-1:0] am0;
    logic [NB_DATA-1:0] d1;

    // Parity straight from the definition: walk payload bits, lane = (b-2)%8.
    function automatic logic [NB_BIP-1:0] blk_parity(input logic [NB_DATA-1:0] blk);
        logic [NB_BIP-1:0] p;
        p = '0;
        for (int b = 2; b < NB_DATA; b++) p[(b - 2) % 8] = p[(b - 2) % 8] ^ blk[b];
        p[3] = p[3] ^ blk[0];
        p[4] = p[4] ^ blk[1];
        return p;
    endfunction

    function automatic logic [NB_DATA-1:0] ins(input logic [NB_DATA-1:0] blk,
                                               input logic [7:0] b3, input logic [7:0] b7);
        logic [NB_DATA-1:0] r;
        r = blk;
        r[33:26] = b3;
        r[65:58] = b7;
        return r;
    endfunction

    function automatic logic [NB_DATA-1:0] rand_block(input bit am);
        logic [NB_DATA-1:0] b;
        b = {2'($urandom), $urandom, $urandom};
        if (am) b[1:0] = 2'b10;
        else    b[1:0] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        return b;
    endfunction

    task automatic check(input string tag, input logic [NB_DATA-1:0] obs,
                         input logic [NB_DATA-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_step(input bit am, input logic [NB_DATA-1:0] blk);
        if (am) begin
            if (rx_locked && ((blk[33:26] !== rx_acc) || (blk[65:58] !== ~rx_acc))) rx_err++;
            rx_acc    = blk_parity(blk);
            rx_locked = 1'b1;
        end else if (rx_locked) begin
            rx_acc = rx_acc ^ blk_parity(blk);
        end
    endtask

    // ---------------- driver: one cycle, predict, then check ----------------
    task automatic drive(input bit en, input bit am, input logic [NB_DATA-1:0] data);
        logic [NB_DATA-1:0] exp_data;
        logic [NB_BIP-1:0]  bip;
        bit                 exp_err;
        int                 n;
        @(negedge clk);
        i_enable    = en;
        i_am_insert = am;
        i_data      = data;
        exp_err     = 1'b0;
        if (en && am) begin
            if (m_locked) begin
                bip = '0;
                foreach (m_q[i]) bip = bip ^ blk_parity(m_q[i]);
                n = m_q.size() - 1;
                if (n > CNT_MAX) n = CNT_MAX;
                exp_err  = (n != AM_PERIOD - 1);
                exp_data = ins(data, bip, ~bip);
            end else begin
                exp_data = ins(data, 8'h00, 8'hFF);
            end
            m_q.delete();
            m_q.push_back(exp_data);
            m_locked = 1'b1;
            m_last   = exp_data;
        end else if (en) begin
            exp_data = data;
            m_q.push_back(data);
            m_last = data;
        end else begin
            exp_data = m_last;
        end
        exp_q.push_back(exp_data);
        @(posedge clk);
        #1;
        check("o_valid", 66'(o_valid), 66'(en));
        check("o_data", o_data, exp_q.pop_front());
        check("o_locked", 66'(o_locked), 66'(m_locked));
        check("o_period_error", 66'(o_period_error), 66'(exp_err));
        if (rx_on && en) rx_step(am, o_data ^ rx_flip);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        i_reset = 1'b0;
        #1;
        check("rst_o_data", o_data, '0);
        check("rst_o_valid", 66'(o_valid), '0);
        check("rst_o_locked", 66'(o_locked), '0);
        check("rst_o_period_error", 66'(o_period_error), '0);
        m_locked = 1'b0;
        m_q.delete();
        exp_q.delete();
        m_last      = '0;
        i_enable    = 1'b0;
        i_am_insert = 1'b0;
        i_data      = '0;
        @(negedge clk);
        i_reset = 1'b1;
    endtask

    task automatic run_period(input int n_data, input bit idles);
        for (int i = 0; i < n_data; i++) begin
            drive(1'b1, 1'b0, rand_block(1'b0));
            if (idles && ($urandom_range(0, 2) == 0))
                drive(1'b0, 1'($urandom_range(0, 1)), rand_block(1'b1));
        end
        drive(1'b1, 1'b1, rand_block(1'b1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        rx_on = 1'b0; rx_locked = 1'b0; rx_acc = '0; rx_err = 0; rx_flip = '0;
        m_locked = 1'b0; m_last = '0;
        i_reset = 1'b0; i_enable = 1'b0; i_am_insert = 1'b0; i_data = '0;
        am0 = 66'd2;   // AM: sync 2'b10, zero payload
        d1  = 66'd1;   // data: sync 2'b01, zero payload

        repeat (2) @(negedge clk);
        apply_reset();

        // Basic period: first AM 00/FF, second AM E7/18 on-period.
        drive(1'b1, 1'b1, am0);
        check("first_am", o_data, ins(am0, 8'h00, 8'hFF));
        repeat (3) drive(1'b1, 1'b0, d1);
        drive(1'b1, 1'b1, am0);
        check("second_am", o_data, ins(am0, 8'hE7, 8'h18));
        check("second_am_err", 66'(o_period_error), '0);

        // Short period in RUN: AM after 2 data blocks.
        repeat (2) drive(1'b1, 1'b0, rand_block(1'b0));
        drive(1'b1, 1'b1, rand_block(1'b1));
        check("short_period_err", 66'(o_period_error), 66'(1));
        drive(1'b0, 1'b0, '0);
        check("short_period_pulse_end", 66'(o_period_error), '0);

        // Same basic sequence with idle cycles (AM flag set while idle too).
        apply_reset();
        drive(1'b1, 1'b1, am0);
        check("idle_first_am", o_data, ins(am0, 8'h00, 8'hFF));
        drive(1'b0, 1'b1, rand_block(1'b1));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, d1);
            drive(1'b0, 1'b0, rand_block(1'b0));
        end
        drive(1'b1, 1'b1, am0);
        check("idle_second_am", o_data, ins(am0, 8'hE7, 8'h18));

        // Counter saturation: 2^N+5 and 2^N+3 data blocks (the latter would
        // look on-period if the counter wrapped).
        repeat (CNT_MAX + 6) drive(1'b1, 1'b0, rand_block(1'b0));
        drive(1'b1, 1'b1, rand_block(1'b1));
        check("sat_21_err", 66'(o_period_error), 66'(1));
        repeat (CNT_MAX + 4) drive(1'b1, 1'b0, rand_block(1'b0));
        drive(1'b1, 1'b1, rand_block(1'b1));
        check("sat_19_err", 66'(o_period_error), 66'(1));
        run_period(3, 1'b0);
        check("back_on_period", 66'(o_period_error), '0);

        // Randomized periods, mostly on-period, with idle cycles.
        for (int p = 0; p < 12; p++) begin
            if ($urandom_range(0, 3) == 0) run_period($urandom_range(0, 6), 1'b1);
            else                           run_period(AM_PERIOD - 1, 1'b1);
        end

        // Reset mid-period discards the partial BIP.
        repeat (2) drive(1'b1, 1'b0, rand_block(1'b0));
        apply_reset();
        drive(1'b1, 1'b0, rand_block(1'b0));
        drive(1'b1, 1'b1, am0);
        check("post_reset_am", o_data, ins(am0, 8'h00, 8'hFF));

        // Loopback into receive-side checker: 5 clean periods, then one flip.
        rx_on = 1'b1; rx_locked = 1'b0; rx_err = 0;
        drive(1'b1, 1'b1, rand_block(1'b1));
        repeat (5) run_period(AM_PERIOD - 1, 1'b1);
        check("rx_err_clean", 66'(rx_err), '0);
        drive(1'b1, 1'b0, rand_block(1'b0));
        rx_flip = 66'd1 << $urandom_range(0, NB_DATA - 1);
        drive(1'b1, 1'b0, rand_block(1'b0));
        rx_flip = '0;
        drive(1'b1, 1'b0, rand_block(1'b0));
        drive(1'b1, 1'b1, rand_block(1'b1));
        check("rx_err_flip", 66'(rx_err), 66'(1));
        rx_on = 1'b0;

        drive(1'b0, 1'b0, '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
